// File: rtl/param_mult.sv
// Unsigned WIDTH_IN x WIDTH_IN array multiplier (ripple-carry rows of full adders)
// with a combinational product and a one-cycle registered copy plus valid flag.
module param_mult #(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH_IN-1:0]  a,
    input  logic [WIDTH_IN-1:0]  b,
    input  logic                 in_valid,
    output logic [WIDTH_OUT-1:0] y,
    output logic [WIDTH_OUT-1:0] y_q,
    output logic                 out_valid
);

    localparam int W  = WIDTH_IN;
    localparam int PW = 2 * WIDTH_IN;

    logic [W-1:0]  pp  [W];
    // acc[i] is the still-unsettled upper part of the running sum after row i
    logic [W-1:0]  acc [W];
    logic [PW-1:0] prod;

    genvar i, j;

    for (i = 0; i < W; i++) begin : g_pp
        assign pp[i] = a & {W{b[i]}};
    end

    assign prod[0] = pp[0][0];
    for (j = 0; j < W - 1; j++) begin : g_row0
        assign acc[0][j] = pp[0][j+1];
    end
    assign acc[0][W-1] = 1'b0;

    for (i = 1; i < W; i++) begin : g_row
        logic [W-1:0] sum;
        logic [W:0]   carry;

        assign carry[0] = 1'b0;
        for (j = 0; j < W; j++) begin : g_fa
            assign sum[j]     = acc[i-1][j] ^ pp[i][j] ^ carry[j];
            assign carry[j+1] = (acc[i-1][j] & pp[i][j])
                              | (acc[i-1][j] & carry[j])
                              | (pp[i][j]    & carry[j]);
        end

        assign prod[i] = sum[0];
        // final carry of the row becomes the top bit of the next accumulator
        if (W > 1) begin : g_shift
            assign acc[i] = {carry[W], sum[W-1:1]};
        end
    end

    assign prod[PW-1:W] = acc[W-1];

    if (WIDTH_OUT <= PW) begin : g_trunc
        assign y = prod[WIDTH_OUT-1:0];
    end else begin : g_zext
        assign y = {{(WIDTH_OUT-PW){1'b0}}, prod};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            y_q       <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            y_q       <= y;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_mult.sv
// Bench for param_mult: default, 4x4->8 and 8x8->8 instances against an arithmetic
// model, plus directed vectors with hand-computed results and an exhaustive y sweep.
module tb_param_mult;

    logic        clk;
    logic        reset;
    logic [7:0]  a, b;
    logic        in_valid;
    logic [15:0] y, y_q;
    logic        out_valid;

    logic [7:0]  y4, y4_q, y88, y88_q;
    logic        ov4, ov88;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 0;

    longint      exp_yq = 0;
    bit          exp_ov = 0;

    param_mult #(.WIDTH_IN(8), .WIDTH_OUT(16)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
        .y(y), .y_q(y_q), .out_valid(out_valid)
    );

    param_mult #(.WIDTH_IN(4), .WIDTH_OUT(8)) dut4 (
        .clk(clk), .reset(reset), .a(a[3:0]), .b(b[3:0]), .in_valid(in_valid),
        .y(y4), .y_q(y4_q), .out_valid(ov4)
    );

    param_mult #(.WIDTH_IN(8), .WIDTH_OUT(8)) dut88 (
        .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
        .y(y88), .y_q(y88_q), .out_valid(ov88)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic longint product(longint x, longint z, int w_in, int w_out);
        longint mask_in = (64'd1 << w_in) - 1;
        return ((x & mask_in) * (z & mask_in)) & ((64'd1 << w_out) - 1);
    endfunction

    task automatic check(string name, longint act, longint expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // registered-path model: whatever was accepted on an edge is what y_q shows
    always @(posedge clk) begin
        if (!reset) begin
            exp_yq = 0;
            exp_ov = 0;
        end else if (in_valid) begin
            exp_yq = product(a, b, 8, 16);
            exp_ov = 1;
        end else begin
            exp_ov = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_y",     y,         product(a, b, 8, 16));
            check("cmp_y4",    y4,        product(a, b, 4, 8));
            check("cmp_y88",   y88,       product(a, b, 8, 8));
            check("cmp_y_q",   y_q,       exp_yq);
            check("cmp_valid", out_valid, exp_ov);
        end
    end

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] vy;
    } vec_t;

    vec_t vecs [8] = '{
        '{8'h12, 8'h34, 16'h03A8},
        '{8'h80, 8'h02, 16'h0100},
        '{8'hFF, 8'h01, 16'h00FF},
        '{8'h10, 8'h10, 16'h0100},
        '{8'hAA, 8'h55, 16'h3872},
        '{8'h7F, 8'h7F, 16'h3F01},
        '{8'hC8, 8'h02, 16'h0190},
        '{8'h02, 8'hFF, 16'h01FE}
    };

    initial begin
        reset    = 0;
        in_valid = 0;
        a        = 8'h00;
        b        = 8'hAB;

        // reset held for two edges
        tick();
        tick();
        chk_en = 1;
        @(negedge clk);
        check("rst_y",     y,         16'h0000);
        check("rst_y_q",   y_q,       16'h0000);
        check("rst_valid", out_valid, 1'b0);

        // combinational corners, still in reset
        a = 8'h01; b = 8'hC3;
        @(negedge clk);
        check("corner_01xC3", y, 16'h00C3);
        a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        check("corner_FFxFF", y,   16'hFE01);
        check("var4_FxF",     y4,  8'hE1);
        check("var88_FFxFF",  y88, 8'h01);
        a = 8'h0F; b = 8'h10;
        @(negedge clk);
        check("corner_0Fx10", y, 16'h00F0);

        // release reset, single capture
        tick();
        reset = 1; in_valid = 1; a = 8'h12; b = 8'h34;
        tick();
        in_valid = 0;
        @(negedge clk);
        check("cap_y_q",   y_q,       16'h03A8);
        check("cap_valid", out_valid, 1'b1);
        a = 8'h99; b = 8'h77;
        tick();
        @(negedge clk);
        check("hold_y_q",   y_q,       16'h03A8);
        check("hold_valid", out_valid, 1'b0);

        // back-to-back
        in_valid = 1; a = 8'd3; b = 8'd5;
        tick();
        a = 8'd200; b = 8'd2;
        @(negedge clk);
        check("b2b_0_y_q",   y_q,       16'd15);
        check("b2b_0_valid", out_valid, 1'b1);
        tick();
        a = 8'd255; b = 8'd1;
        @(negedge clk);
        check("b2b_1_y_q",   y_q,       16'd400);
        check("b2b_1_valid", out_valid, 1'b1);
        tick();
        in_valid = 0;
        @(negedge clk);
        check("b2b_2_y_q",   y_q,       16'd255);
        check("b2b_2_valid", out_valid, 1'b1);

        // reset overrides in_valid
        tick();
        reset = 0; in_valid = 1; a = 8'hFF; b = 8'hFF;
        tick();
        @(negedge clk);
        check("ovr_y_q",   y_q,       16'h0000);
        check("ovr_valid", out_valid, 1'b0);
        check("ovr_y",     y,         16'hFE01);

        // capture discarded by a following reset edge
        reset = 1; a = 8'd2; b = 8'd3;
        tick();
        reset = 0; in_valid = 0;
        @(negedge clk);
        check("mid_y_q",   y_q,       16'd6);
        check("mid_valid", out_valid, 1'b1);
        tick();
        @(negedge clk);
        check("mid_rst_y_q",   y_q,       16'h0000);
        check("mid_rst_valid", out_valid, 1'b0);
        reset = 1;

        // directed vector table, one per cycle through the registered path too
        tick();
        in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            a = vecs[k].va;
            b = vecs[k].vb;
            @(negedge clk);
            check("vec_y", y, vecs[k].vy);
            tick();
        end
        in_valid = 0;
        @(negedge clk);
        check("vec_last_y_q", y_q, 16'h01FE);
        tick();

        // exhaustive combinational sweep of all three instances
        chk_en = 0;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                a = i[7:0];
                b = j[7:0];
                #1;
                check("sweep_y",   y,   product(i, j, 8, 16));
                check("sweep_y4",  y4,  product(i, j, 4, 8));
                check("sweep_y88", y88, product(i, j, 8, 8));
            end
        end
        tick();
        chk_en = 1;
        @(negedge clk);
        tick();

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
